// File: rtl/key_debounce_multi.sv
// Multi-channel push-button debouncer: 2-flop synchroniser, symmetric debounce filter and
// long-press detector per channel, with registered level and single-cycle event pulses.
module key_debounce_multi #(
    parameter int unsigned NUM_KEYS   = 4,
    parameter int unsigned SYS_CLK    = 50_000_000,
    parameter int unsigned FILTER_MS  = 20,
    parameter int unsigned LONG_MS    = 1000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int unsigned FILTER_CYC = SYS_CLK / 1000 * FILTER_MS;
    localparam int unsigned LONG_CYC   = SYS_CLK / 1000 * LONG_MS;

    // Width guards keep declarations legal long enough for the checks below to report.
    localparam int unsigned FCW = (FILTER_CYC < 2) ? 1 : $clog2(FILTER_CYC);
    localparam int unsigned LCW = (LONG_CYC < 1) ? 1 : $clog2(LONG_CYC + 1);

    localparam logic [FCW-1:0] FILTER_MAX = FCW'(FILTER_CYC - 1);
    localparam logic [LCW-1:0] LONG_MAX   = LCW'(LONG_CYC - 1);
    localparam logic           IDLE_LVL   = ACTIVE_LOW;

    if (FILTER_CYC < 2) begin : g_bad_filter
        $error("key_debounce_multi: FILTER_CYC must be >= 2");
    end
    if (LONG_CYC < 1) begin : g_bad_long
        $error("key_debounce_multi: LONG_CYC must be >= 1");
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic           sync1_q;
        logic           sync2_q;
        logic           s2;
        logic [FCW-1:0] cnt_q, cnt_d;
        logic           state_q, state_d;
        logic           press_q, press_d;
        logic           release_q, release_d;
        logic [LCW-1:0] lcnt_q, lcnt_d;
        logic           fired_q, fired_d;
        logic           long_q, long_d;

        // Normalised level: 1 = pressed, independent of pin polarity.
        assign s2 = sync2_q ^ ACTIVE_LOW;

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (s2 == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == FILTER_MAX) begin
                state_d   = s2;
                cnt_d     = '0;
                press_d   = s2;
                release_d = ~s2;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Long counter saturates at the threshold so each press fires at most once.
        always_comb begin
            lcnt_d  = lcnt_q;
            fired_d = fired_q;
            long_d  = 1'b0;
            if (!state_q) begin
                lcnt_d  = '0;
                fired_d = 1'b0;
            end else if (!fired_q) begin
                if (lcnt_q == LONG_MAX) begin
                    long_d  = 1'b1;
                    fired_d = 1'b1;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q   <= IDLE_LVL;
                sync2_q   <= IDLE_LVL;
                cnt_q     <= '0;
                state_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                lcnt_q    <= '0;
                fired_q   <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                sync1_q   <= key_in[k];
                sync2_q   <= sync1_q;
                cnt_q     <= cnt_d;
                state_q   <= state_d;
                press_q   <= press_d;
                release_q <= release_d;
                lcnt_q    <= lcnt_d;
                fired_q   <= fired_d;
                long_q    <= long_d;
            end
        end

        assign key_state[k]   = state_q;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;
        assign key_long[k]    = long_q;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: one active-low and one active-high instance,
// directed key sequences with hand-computed event cycles.
module tb_key_debounce_multi;

    typedef struct packed {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
        logic [3:0] state;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_a, key_b;
    logic [3:0] st_a, pr_a, rl_a, lg_a;
    logic [3:0] st_b, pr_b, rl_b, lg_b;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    ev_t qa[$];
    ev_t qb[$];

    key_debounce_multi #(
        .NUM_KEYS(4), .SYS_CLK(10_000), .FILTER_MS(1), .LONG_MS(5), .ACTIVE_LOW(1'b1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .key_in(key_a),
        .key_state(st_a), .key_press(pr_a), .key_release(rl_a), .key_long(lg_a)
    );

    key_debounce_multi #(
        .NUM_KEYS(4), .SYS_CLK(10_000), .FILTER_MS(1), .LONG_MS(5), .ACTIVE_LOW(1'b0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .key_in(key_b),
        .key_state(st_b), .key_press(pr_b), .key_release(rl_b), .key_long(lg_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsz(input int d);
        return (d == 0) ? qa.size() : qb.size();
    endfunction

    function automatic ev_t qfront(input int d);
        return (d == 0) ? qa[0] : qb[0];
    endfunction

    task automatic qpop(input int d);
        if (d == 0) qa.delete(0);
        else qb.delete(0);
    endtask

    task automatic push(input int d, input int at, input logic [3:0] p, input logic [3:0] r,
                        input logic [3:0] l, input logic [3:0] s);
        ev_t e;
        e.cyc = at; e.press = p; e.rel = r; e.lng = l; e.state = s;
        if (d == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    task automatic mon(input int d, input logic [3:0] st, input logic [3:0] pr,
                       input logic [3:0] rl, input logic [3:0] lg);
        ev_t   e;
        string tag;
        tag = (d == 0) ? "dut_a" : "dut_b";
        while (qsz(d) > 0 && qfront(d).cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s missed event: got no pulse at cycle %0d, expected one", tag,
                     qfront(d).cyc);
            qpop(d);
        end
        if (|{pr, rl, lg}) begin
            if (qsz(d) == 0 || qfront(d).cyc != cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s unexpected pulse: got press=%b release=%b long=%b at cycle %0d, expected none",
                         tag, pr, rl, lg, cyc);
            end else begin
                e = qfront(d);
                qpop(d);
                chk({tag, " key_press"}, 32'(pr), 32'(e.press));
                chk({tag, " key_release"}, 32'(rl), 32'(e.rel));
                chk({tag, " key_long"}, 32'(lg), 32'(e.lng));
                chk({tag, " key_state at event"}, 32'(st), 32'(e.state));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, st_a, pr_a, rl_a, lg_a);
        mon(1, st_b, pr_b, rl_b, lg_b);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle_check(input logic [3:0] exp_a, input logic [3:0] exp_b);
        @(negedge clk);
        chk("dut_a settled key_state", 32'(st_a), 32'(exp_a));
        chk("dut_b settled key_state", 32'(st_b), 32'(exp_b));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " a key_state"}, 32'(st_a), 0);
        chk({name, " a key_press"}, 32'(pr_a), 0);
        chk({name, " a key_release"}, 32'(rl_a), 0);
        chk({name, " a key_long"}, 32'(lg_a), 0);
        chk({name, " b key_state"}, 32'(st_b), 0);
        chk({name, " b outputs"}, 32'({pr_b, rl_b, lg_b}), 0);
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: got no completion by cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int u;
        rst_n = 1'b0;
        key_a = 4'hF;
        key_b = 4'h0;
        wait_cyc(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        wait_cyc(20);
        settle_check(4'b0000, 4'b0000);

        // Clean press then release.
        t = cyc; key_a[0] = 1'b0;
        push(0, t + 12, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        wait_cyc(20);
        settle_check(4'b0001, 4'b0000);
        t = cyc; key_a[0] = 1'b1;
        push(0, t + 12, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        wait_cyc(20);
        settle_check(4'b0000, 4'b0000);

        // Bounce: four short low bursts produce nothing.
        for (int i = 0; i < 4; i++) begin
            key_a[0] = 1'b0; wait_cyc(6);
            key_a[0] = 1'b1; wait_cyc(3);
        end
        t = cyc; key_a[0] = 1'b0;
        push(0, t + 12, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        wait_cyc(20);
        t = cyc; key_a[0] = 1'b1;
        push(0, t + 12, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        wait_cyc(20);
        settle_check(4'b0000, 4'b0000);

        // Long press: one key_long 50 edges after the press, then a short press without one.
        t = cyc; key_a[0] = 1'b0;
        push(0, t + 12, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        push(0, t + 62, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        wait_cyc(120);
        t = cyc; key_a[0] = 1'b1;
        push(0, t + 12, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        wait_cyc(20);
        t = cyc; key_a[0] = 1'b0;
        push(0, t + 12, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        wait_cyc(30);
        t = cyc; key_a[0] = 1'b1;
        push(0, t + 12, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        wait_cyc(20);
        settle_check(4'b0000, 4'b0000);

        // Simultaneous presses on independent channels.
        t = cyc; key_a[1] = 1'b0; key_a[3] = 1'b0;
        push(0, t + 12, 4'b1010, 4'b0000, 4'b0000, 4'b1010);
        wait_cyc(3);
        key_a[2] = 1'b0;
        push(0, t + 15, 4'b0100, 4'b0000, 4'b0000, 4'b1110);
        wait_cyc(17);
        key_a = 4'hF;
        push(0, t + 32, 4'b0000, 4'b1110, 4'b0000, 4'b0000);
        wait_cyc(20);
        settle_check(4'b0000, 4'b0000);

        // Reset mid-count with key 3 already pressed and key 0 half-counted.
        t = cyc; key_a[3] = 1'b0;
        push(0, t + 12, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
        wait_cyc(20);
        u = cyc; key_a[0] = 1'b0;
        wait_cyc(6);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid-op reset");
        wait_cyc(2);
        rst_n = 1'b1;
        push(0, u + 20, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
        wait_cyc(17);
        key_a = 4'hF;
        push(0, u + 37, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
        wait_cyc(20);
        settle_check(4'b0000, 4'b0000);

        // Active-high instance: press, 9-cycle release glitch ignored, real release.
        t = cyc; key_b[0] = 1'b1;
        push(1, t + 12, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        wait_cyc(20);
        key_b[0] = 1'b0; wait_cyc(9);
        key_b[0] = 1'b1; wait_cyc(11);
        settle_check(4'b0000, 4'b0001);
        t = cyc; key_b[0] = 1'b0;
        push(1, t + 12, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        wait_cyc(20);
        settle_check(4'b0000, 4'b0000);

        for (int i = 0; i < 300 && (qa.size() + qb.size()) > 0; i++) @(posedge clk);
        wait_cyc(2);
        chk("scoreboard drained", 32'(qa.size() + qb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
